// File: rtl/io_loader_if.sv
// Load-request, source-stream and bank-write signals of the io_loader.
interface io_loader_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 8
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          abort;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_o;
    logic          busy;
    logic          done;
    logic [AW:0]   count;

    // Requester/source side.
    modport master (
        output start, base_addr, len, abort, in_valid, in_data,
        input  in_ready, we, addr, data_o, busy, done, count
    );

    // Loader side.
    modport slave (
        input  start, base_addr, len, abort, in_valid, in_data,
        output in_ready, we, addr, data_o, busy, done, count
    );
endinterface

// File: rtl/io_loader.sv
// Streams len source bytes into consecutive byte slots of a register bank,
// starting at base_addr and wrapping modulo NBYTES.
module io_loader #(
    parameter int unsigned NBYTES = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned DW     = 8
) (
    input  logic        clk,
    input  logic        rst,
    io_loader_if.slave  bus
);
    localparam logic [AW:0] NBytesW = (AW+1)'(NBYTES);
    localparam logic [AW:0] OneW    = (AW+1)'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StFin} state_e;

    state_e        state_q;
    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [AW:0]   count_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    logic          in_ready;
    logic          accept;
    logic [AW:0]   slot_sum;
    logic [AW-1:0] slot;

    assign in_ready = (state_q == StLoad) && (count_q < len_q);
    assign accept   = bus.in_valid && in_ready;

    // Slot for the byte being accepted: base plus index, wrapped into the bank.
    always_comb begin
        slot_sum = {1'b0, base_q} + count_q;
        if (slot_sum >= NBytesW) begin
            slot_sum = slot_sum - NBytesW;
        end
        slot = slot_sum[AW-1:0];
    end

    // Load FSM with registered write port; abort outranks completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        base_q  <= bus.base_addr;
                        len_q   <= bus.len;
                        count_q <= '0;
                        state_q <= (bus.len == '0) ? StFin : StLoad;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        we_q    <= 1'b1;
                        addr_q  <= slot;
                        data_q  <= bus.in_data;
                        count_q <= count_q + OneW;
                    end
                    if (bus.abort) begin
                        state_q <= StIdle;
                    end else if (accept && (count_q + OneW == len_q)) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.we       = we_q;
    assign bus.addr     = addr_q;
    assign bus.data_o   = data_q;
    assign bus.count    = count_q;
    assign bus.busy     = (state_q != StIdle);
    // FIN lasts one cycle and coincides with the final write strobe.
    assign bus.done     = (state_q == StFin);
endmodule

// File: tb/tb_io_loader.sv
// Directed self-checking bench for io_loader.
module tb_io_loader;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    io_loader_if #(.AW(5), .DW(8)) bus ();

    io_loader #(.NBYTES(32), .AW(5), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        total_cnt++;
        if ({bus.in_ready, bus.we, bus.busy, bus.done} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000",
                     {bus.in_ready, bus.we, bus.busy, bus.done});
        else pass_cnt++;
        total_cnt++;
        if ({bus.addr, bus.data_o, bus.count} !== 19'd0)
            $display("FAIL reset_values addr=%0d data=%0h count=%0d want 0",
                     bus.addr, bus.data_o, bus.count);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    // Start is presented straight after reset release: first edge must take it.
    task automatic test_full_load();
        bus.start = 1'b1; bus.base_addr = 5'd0; bus.len = 6'd32;
        step();
        bus.start = 1'b0;
        total_cnt++;
        if ({bus.busy, bus.in_ready, bus.we} !== 3'b110)
            $display("FAIL full_start busy/ready/we got %b want 110",
                     {bus.busy, bus.in_ready, bus.we});
        else pass_cnt++;
        for (int i = 0; i < 32; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            step();
            total_cnt++;
            if (bus.we !== 1'b1 || bus.addr !== 5'(i) || bus.data_o !== 8'(i) ||
                bus.count !== 6'(i + 1) || bus.done !== (i == 31))
                $display("FAIL full_write%0d we=%b addr=%0d data=%0h count=%0d done=%b want 1 %0d %0h %0d %b",
                         i, bus.we, bus.addr, bus.data_o, bus.count, bus.done,
                         i, i, i + 1, (i == 31));
            else pass_cnt++;
        end
        bus.in_valid = 1'b0;
        step();
        total_cnt++;
        if ({bus.we, bus.done, bus.busy} !== 3'b000 || bus.count !== 6'd32)
            $display("FAIL full_end we/done/busy=%b count=%0d want 000 32",
                     {bus.we, bus.done, bus.busy}, bus.count);
        else pass_cnt++;
    endtask

    task automatic test_wrap_stall();
        logic [4:0] exp_addr [4];
        int         k;
        int         dones;
        exp_addr = '{5'd30, 5'd31, 5'd0, 5'd1};
        k = 0;
        dones = 0;
        bus.start = 1'b1; bus.base_addr = 5'd30; bus.len = 6'd4;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = (i % 2 == 0) ? 8'hA0 + 8'(i) : 8'h55;
            step();
            if (bus.done === 1'b1) dones++;
            if (i % 2 == 0) begin
                total_cnt++;
                if (bus.we !== 1'b1 || bus.addr !== exp_addr[k] ||
                    bus.data_o !== 8'hA0 + 8'(i))
                    $display("FAIL wrap_write%0d we=%b addr=%0d data=%0h want 1 %0d %0h",
                             k, bus.we, bus.addr, bus.data_o, exp_addr[k], 8'hA0 + 8'(i));
                else pass_cnt++;
                k++;
            end else begin
                total_cnt++;
                if (bus.we !== 1'b0 || bus.addr !== exp_addr[k-1] ||
                    bus.data_o !== 8'hA0 + 8'(i - 1))
                    $display("FAIL wrap_stall%0d we=%b addr=%0d data=%0h want 0 %0d %0h",
                             i, bus.we, bus.addr, bus.data_o, exp_addr[k-1],
                             8'hA0 + 8'(i - 1));
                else pass_cnt++;
            end
        end
        bus.in_valid = 1'b0;
        step();
        if (bus.done === 1'b1) dones++;
        total_cnt++;
        if (dones != 1 || bus.busy !== 1'b0 || bus.count !== 6'd4)
            $display("FAIL wrap_end dones=%0d busy=%b count=%0d want 1 0 4",
                     dones, bus.busy, bus.count);
        else pass_cnt++;
    endtask

    task automatic test_zero_len();
        int busy_cycles;
        int dones;
        int wes;
        busy_cycles = 0; dones = 0; wes = 0;
        bus.start = 1'b1; bus.base_addr = 5'd7; bus.len = 6'd0;
        step();
        bus.start = 1'b0;
        total_cnt++;
        if ({bus.busy, bus.done, bus.in_ready} !== 3'b110 || bus.count !== 6'd0)
            $display("FAIL zero_fin busy/done/ready=%b count=%0d want 110 0",
                     {bus.busy, bus.done, bus.in_ready}, bus.count);
        else pass_cnt++;
        busy_cycles++; dones++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1) dones++;
            if (bus.we === 1'b1) wes++;
        end
        total_cnt++;
        if (busy_cycles != 1 || dones != 1 || wes != 0)
            $display("FAIL zero_counts busy=%0d done=%0d we=%0d want 1 1 0",
                     busy_cycles, dones, wes);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [7:0] bytes [3];
        bytes = '{8'h11, 8'h22, 8'h33};
        bus.start = 1'b1; bus.base_addr = 5'd4; bus.len = 6'd8;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bytes[i];
            bus.abort    = (i == 2);
            step();
            total_cnt++;
            if (bus.we !== 1'b1 || bus.addr !== 5'(4 + i) || bus.data_o !== bytes[i] ||
                bus.done !== 1'b0)
                $display("FAIL abort_write%0d we=%b addr=%0d data=%0h done=%b want 1 %0d %0h 0",
                         i, bus.we, bus.addr, bus.data_o, bus.done, 4 + i, bytes[i]);
            else pass_cnt++;
        end
        bus.abort = 1'b0;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.count !== 6'd3 || bus.in_ready !== 1'b0)
            $display("FAIL abort_idle busy=%b count=%0d ready=%b want 0 3 0",
                     bus.busy, bus.count, bus.in_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.we !== 1'b0 || bus.done !== 1'b0 || bus.count !== 6'd3)
            $display("FAIL abort_after we=%b done=%b count=%0d want 0 0 3",
                     bus.we, bus.done, bus.count);
        else pass_cnt++;
        bus.in_valid = 1'b0;
        bus.start = 1'b1; bus.base_addr = 5'd9; bus.len = 6'd1;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h44;
        step();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.we !== 1'b1 || bus.addr !== 5'd9 || bus.data_o !== 8'h44 ||
            bus.done !== 1'b1 || bus.count !== 6'd1)
            $display("FAIL abort_restart we=%b addr=%0d data=%0h done=%b count=%0d want 1 9 44 1 1",
                     bus.we, bus.addr, bus.data_o, bus.done, bus.count);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_load();
        int bad;
        bad = 0;
        bus.start = 1'b1; bus.base_addr = 5'd12; bus.len = 6'd10;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hE0 + 8'(i);
            step();
        end
        total_cnt++;
        if (bus.we !== 1'b1 || bus.addr !== 5'd16 || bus.count !== 6'd5)
            $display("FAIL rstmid_pre we=%b addr=%0d count=%0d want 1 16 5",
                     bus.we, bus.addr, bus.count);
        else pass_cnt++;
        bus.in_data = 8'hE5;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.in_ready, bus.we, bus.busy, bus.done} !== 4'b0000 ||
            {bus.addr, bus.data_o, bus.count} !== 19'd0)
            $display("FAIL rstmid_async flags=%b addr=%0d data=%0h count=%0d want 0000 0 0 0",
                     {bus.in_ready, bus.we, bus.busy, bus.done}, bus.addr, bus.data_o,
                     bus.count);
        else pass_cnt++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.we !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bad != 0)
            $display("FAIL rstmid_quiet bad_cycles=%0d want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        bus.start = 1'b1; bus.base_addr = 5'd2; bus.len = 6'd3;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.start = 1'b1; bus.base_addr = 5'd20; bus.len = 6'd7;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hC0 + 8'(i);
            step();
            total_cnt++;
            if (bus.we !== 1'b1 || bus.addr !== 5'(2 + i) || bus.data_o !== 8'hC0 + 8'(i) ||
                bus.count !== 6'(i + 1) || bus.done !== (i == 2))
                $display("FAIL ign_write%0d we=%b addr=%0d data=%0h count=%0d done=%b want 1 %0d %0h %0d %b",
                         i, bus.we, bus.addr, bus.data_o, bus.count, bus.done,
                         2 + i, 8'hC0 + 8'(i), i + 1, (i == 2));
            else pass_cnt++;
        end
        bus.in_valid = 1'b0;
        step();
        bus.start = 1'b0;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.count !== 6'd3 || bus.we !== 1'b0)
            $display("FAIL ign_fin busy=%b count=%0d we=%b want 0 3 0",
                     bus.busy, bus.count, bus.we);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_full_load();
        test_wrap_stall();
        test_zero_len();
        test_abort();
        test_reset_mid_load();
        test_start_ignored();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/io_loader.md
IO_LOADER -- requirements
Module: io_loader

Interface
REQ-001 SHALL have parameter NBYTES, default 32, meaning the number of byte slots in the target 256-bit register bank.
REQ-002 SHALL have parameter AW, default 5, meaning the slot address width (log2 NBYTES).
REQ-003 SHALL have parameter DW, default 8, meaning the slot data width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle load request.
REQ-007 SHALL have port base_addr  input  AW  first slot of the load, sampled with start.
REQ-008 SHALL have port len  input  AW+1  byte count of the load, 0..NBYTES, sampled with start.
REQ-009 SHALL have port abort  input  1  terminates an active load.
REQ-010 SHALL have port in_valid  input  1  the source presents a byte.
REQ-011 SHALL have port in_data  input  DW  the source byte.
REQ-012 SHALL have port in_ready  output  1  the loader accepts a byte this cycle.
REQ-013 SHALL have port we  output  1  bank write strobe.
REQ-014 SHALL have port addr  output  AW  bank slot address.
REQ-015 SHALL have port data_o  output  DW  bank write data.
REQ-016 SHALL have port busy  output  1  a load is active.
REQ-017 SHALL have port done  output  1  one-cycle pulse that the load completed normally.
REQ-018 SHALL have port count  output  AW+1  bytes accepted in the current or most recent load.

Function
REQ-019 SHALL implement the states IDLE, LOAD and FIN.
REQ-020 In IDLE, start=1 with len>0 SHALL latch base_addr and len, clear count, and enter LOAD on the next edge.
REQ-021 In IDLE, start=1 with len=0 SHALL perform no writes, go to FIN, and pulse done exactly once.
REQ-022 start SHALL be ignored in LOAD and FIN.
REQ-023 in_ready SHALL equal 1 exactly when the state is LOAD and the accepted count is below the latched len.
REQ-024 A byte is accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-025 For a byte accepted in cycle N, the outputs in cycle N+1 SHALL be we=1, data_o=the accepted byte, and addr=(base_addr+index) mod NBYTES; latency is exactly 1 cycle.
REQ-026 we SHALL be 0 in every cycle that does not follow an accepted byte.
REQ-027 addr and data_o SHALL hold their previous values when we=0.
REQ-028 The slot address SHALL wrap from NBYTES-1 to 0; for example base=30 and len=4 writes slots 30, 31, 0, 1.
REQ-029 count SHALL increment by 1 per accepted byte, saturate at len, and hold after the load ends until the next accepted start.
REQ-030 When the len-th byte is accepted, the state SHALL go to FIN; in FIN, done=1 for one cycle, coincident with the final we, then the state returns to IDLE.
REQ-031 busy SHALL be 1 in LOAD and FIN and 0 in IDLE.
REQ-032 Source stalls (in_valid=0) SHALL be tolerated indefinitely in LOAD with no timeout.
REQ-033 abort=1 in LOAD SHALL return the state to IDLE on the next edge with no done pulse.
REQ-034 A byte accepted in the same cycle as abort SHALL still be written in the following cycle and counted.
REQ-035 abort SHALL be ignored in IDLE and FIN.
REQ-036 If the len-th byte is accepted in the same cycle as abort, abort SHALL take priority: the byte is written, but there is no FIN and no done.

Reset
REQ-037 While rst=1, the block SHALL immediately be in state IDLE with in_ready=0, we=0, addr=0, data_o=0, busy=0, done=0 and count=0, regardless of clk.
REQ-038 rst asserted during LOAD SHALL abandon the load, suppress any pending write strobe, and emit no done.
REQ-039 After rst deasserts, the first start SHALL be honoured on the first rising clk edge.

Verification
REQ-040 Full load: start, base=0, len=32, and in_valid held high with in_data=0x00..0x1F -> we for 32 consecutive cycles beginning 1 cycle after the first accept, addr 0..31, data equal to addr, done on the 32nd write, count=32.
REQ-041 Wrap with stalls: base=30, len=4, with in_valid toggling 1,0,1,0 -> writes to slots 30, 31, 0, 1 only on the cycle after each accept, done once.
REQ-042 Zero length: start with len=0 -> no we, done pulse once, busy high for exactly 1 cycle.
REQ-043 Abort: len=8, abort in the same cycle as the 3rd accept -> 3 writes, no done, busy=0 the next cycle, count=3; a subsequent start is honoured.
REQ-044 Reset mid-load: rst asserted between clock edges after 5 of 10 accepts -> outputs go to reset values without waiting for clk, no further we or done.
REQ-045 Start ignored: a second start during LOAD with different base/len -> the original load completes unchanged.
